// File: rtl/weight_bias_store_if.sv
// weight_bias_store_if: load stream and weight/bias fetch signals of the parameter store.
//   master : the engine / loader side (drives load control, byte stream and read addresses)
//   slave  : the store itself (returns registered read data and load status)
//   load_start    one-cycle pulse that begins a new load
//   in_byte/in_valid  stream byte and its one-cycle strobe
//   weight_addr/weight_data  int8 weight read port (data registered, 1-cycle latency)
//   bias_addr/bias_data      32-bit bias read port (data registered, 1-cycle latency)
//   weights_ready, loading, load_error  load status
interface weight_bias_store_if;
    logic        load_start;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic [12:0] weight_addr;
    logic [7:0]  weight_data;
    logic [3:0]  bias_addr;
    logic [31:0] bias_data;
    logic        weights_ready;
    logic        loading;
    logic        load_error;

    modport master (
        output load_start, in_byte, in_valid, weight_addr, bias_addr,
        input  weight_data, bias_data, weights_ready, loading, load_error
    );

    modport slave (
        input  load_start, in_byte, in_valid, weight_addr, bias_addr,
        output weight_data, bias_data, weights_ready, loading, load_error
    );
endinterface

// File: rtl/weight_bias_store.sv
// weight_bias_store: parameter memory for the inference engine.
// Fills an int8 weight RAM (class-major, addr = class*NUM_INPUTS + pixel) followed by a
// little-endian 32-bit bias RAM from a byte stream, then raises weights_ready. Both read
// ports return registered data one cycle after the address, in every state.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset (RAM contents are kept)
//   wb   weight_bias_store_if.slave (load stream, read ports, status)
// Optional build macro WBS_CHECKSUM_EN: after the 7880 payload bytes one extra byte must
// equal the XOR of the payload; a mismatch returns to idle and sets load_error.
module weight_bias_store #(
    parameter int unsigned NUM_CLASSES  = 10,
    parameter int unsigned NUM_INPUTS   = 784,
    parameter int unsigned WEIGHT_DEPTH = NUM_CLASSES * NUM_INPUTS
) (
    input logic               clk,
    input logic               rst,
    weight_bias_store_if.slave wb
);

    localparam int unsigned BiasBytes = NUM_CLASSES * 4;
    localparam logic [12:0] LastW     = 13'(WEIGHT_DEPTH - 1);
    localparam logic [12:0] LastB     = 13'(BiasBytes - 1);
    localparam logic [12:0] DepthW    = 13'(WEIGHT_DEPTH);
    localparam logic [3:0]  DepthB    = 4'(NUM_CLASSES);

`ifdef WBS_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StLoadW, StLoadB, StCheck, StReady} state_e;
`else
    typedef enum logic [2:0] {StIdle, StLoadW, StLoadB, StReady} state_e;
`endif

    state_e      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [23:0] bias_sr_q, bias_sr_d;  // first three bytes of the bias word, LSB first
    logic [7:0]  weight_data_q;
    logic [31:0] bias_data_q;
    logic        we_w, we_b;
    logic        last_w, last_b;

    logic [7:0]  ram_w [WEIGHT_DEPTH];
    logic [31:0] ram_b [NUM_CLASSES];

`ifdef WBS_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;
    logic       load_error_q, load_error_d;
`endif

    assign last_w = (cnt_q == LastW);
    assign last_b = (cnt_q == LastB);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load_start overrides everything, including a coincident byte
    always_comb begin
        state_d = state_q;
        if (wb.load_start) begin
            state_d = StLoadW;
        end else begin
            case (state_q)
                StLoadW: if (wb.in_valid && last_w) state_d = StLoadB;
`ifdef WBS_CHECKSUM_EN
                StLoadB: if (wb.in_valid && last_b) state_d = StCheck;
                StCheck: if (wb.in_valid) state_d = (wb.in_byte == xor_q) ? StReady : StIdle;
`else
                StLoadB: if (wb.in_valid && last_b) state_d = StReady;
`endif
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
`ifdef WBS_CHECKSUM_EN
        wb.loading    = (state_q == StLoadW) || (state_q == StLoadB) || (state_q == StCheck);
        wb.load_error = load_error_q;
`else
        wb.loading    = (state_q == StLoadW) || (state_q == StLoadB);
        wb.load_error = 1'b0;
`endif
        wb.weights_ready = (state_q == StReady);
        wb.weight_data   = weight_data_q;
        wb.bias_data     = bias_data_q;
    end

    // Datapath next-state: byte counter, bias assembly, write enables, checksum
    always_comb begin
        cnt_d     = cnt_q;
        bias_sr_d = bias_sr_q;
        we_w      = 1'b0;
        we_b      = 1'b0;
`ifdef WBS_CHECKSUM_EN
        xor_d        = xor_q;
        load_error_d = load_error_q;
`endif
        if (wb.load_start) begin
            cnt_d = '0;
`ifdef WBS_CHECKSUM_EN
            xor_d        = '0;
            load_error_d = 1'b0;
`endif
        end else if (wb.in_valid) begin
            case (state_q)
                StLoadW: begin
                    we_w  = 1'b1;
                    cnt_d = last_w ? 13'd0 : cnt_q + 13'd1;
`ifdef WBS_CHECKSUM_EN
                    xor_d = xor_q ^ wb.in_byte;
`endif
                end
                StLoadB: begin
                    bias_sr_d = {wb.in_byte, bias_sr_q[23:8]};
                    we_b      = (cnt_q[1:0] == 2'd3);
                    cnt_d     = last_b ? 13'd0 : cnt_q + 13'd1;
`ifdef WBS_CHECKSUM_EN
                    xor_d = xor_q ^ wb.in_byte;
`endif
                end
`ifdef WBS_CHECKSUM_EN
                StCheck: load_error_d = (wb.in_byte != xor_q);
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bias_sr_q <= '0;
`ifdef WBS_CHECKSUM_EN
            xor_q        <= '0;
            load_error_q <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            bias_sr_q <= bias_sr_d;
`ifdef WBS_CHECKSUM_EN
            xor_q        <= xor_d;
            load_error_q <= load_error_d;
`endif
        end
    end

    // RAM writes; no reset so contents survive rst
    always_ff @(posedge clk) begin
        if (we_w && !rst) ram_w[cnt_q] <= wb.in_byte;
        if (we_b && !rst) ram_b[cnt_q[5:2]] <= {wb.in_byte, bias_sr_q};
    end

    // Registered reads; same-address write in this cycle yields the old word
    always_ff @(posedge clk) begin
        if (rst) begin
            weight_data_q <= '0;
            bias_data_q   <= '0;
        end else begin
            weight_data_q <= (wb.weight_addr < DepthW) ? ram_w[wb.weight_addr] : 8'd0;
            bias_data_q   <= (wb.bias_addr < DepthB) ? ram_b[wb.bias_addr] : 32'd0;
        end
    end

endmodule

// File: tb/tb_weight_bias_store.sv
module tb_weight_bias_store;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    typedef struct {
        bit          chk;
        string       tag;
        logic [7:0]  ew;
        logic [31:0] eb;
    } exp_t;

    exp_t sb[$];

    weight_bias_store_if ifc ();

    weight_bias_store dut (
        .clk (clk),
        .rst (rst),
        .wb  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL timeout: observed no end of test, required $finish within budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: compare the read issued last cycle, then drive this cycle's inputs.
    task automatic tick(input bit ls, input bit iv, input logic [7:0] b, input int wa,
                        input int ba, input bit chk, input string tag, input int ew,
                        input logic [31:0] eb);
        exp_t e;
        @(negedge clk);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                check({e.tag, "/weight"}, 32'(ifc.weight_data), 32'(e.ew));
                check({e.tag, "/bias"}, ifc.bias_data, e.eb);
            end
        end
        ifc.load_start  = ls;
        ifc.in_valid    = iv;
        ifc.in_byte     = b;
        ifc.weight_addr = 13'(wa);
        ifc.bias_addr   = 4'(ba);
        e.chk = chk;
        e.tag = tag;
        e.ew  = 8'(ew);
        e.eb  = eb;
        sb.push_back(e);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 8'h00, 0, 0, 1'b0, "", 0, 32'd0);
    endtask

    task automatic rd(input string tag, input int wa, input int ba, input int ew,
                      input logic [31:0] eb);
        tick(1'b0, 1'b0, 8'h00, wa, ba, 1'b1, tag, ew, eb);
    endtask

    function automatic logic [7:0] wbyte(input int mode, input int k);
        if (mode == 0) return 8'(k % 256);
        return (k == 0) ? 8'h01 : 8'h81;
    endfunction

    function automatic logic [31:0] bval(input int mode, input int j);
        if (mode == 0) return 32'(j * 10000);
        return 32'd0 - 32'(j);
    endfunction

    // Sends a whole image (plus checksum byte when enabled), back-to-back.
    task automatic send_load(input int mode, input bit good);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] bv;
        x = 8'h00;
        for (int k = 0; k < 7840; k++) begin
            b = wbyte(mode, k);
            x = x ^ b;
            if (mode == 1 && k == 10) tick(1'b0, 1'b1, b, 10, 0, 1'b1, "rdw_old", 8'h55, 32'd0);
            else if (mode == 1 && k == 11) tick(1'b0, 1'b1, b, 10, 0, 1'b1, "rdw_new", 8'h81, 32'd0);
            else if (mode == 1 && k == 100)
                tick(1'b0, 1'b1, b, 2000, 0, 1'b1, "partial", 8'hD0, 32'd0);
            else tick(1'b0, 1'b1, b, 0, 0, 1'b0, "", 0, 32'd0);
            if (k == 1) check("loading_w", 32'(ifc.loading), 32'd1);
            if (k == 5000) check("ready_midload", 32'(ifc.weights_ready), 32'd0);
        end
        for (int j = 0; j < 10; j++) begin
            bv = bval(mode, j);
            for (int i = 0; i < 4; i++) begin
                b = bv[8*i +: 8];
                x = x ^ b;
                tick(1'b0, 1'b1, b, 0, 0, 1'b0, "", 0, 32'd0);
            end
        end
        check("ready_before_last", 32'(ifc.weights_ready), 32'd0);
`ifdef WBS_CHECKSUM_EN
        tick(1'b0, 1'b1, good ? x : (x ^ 8'h01), 0, 0, 1'b0, "", 0, 32'd0);
        check("ready_before_chk", 32'(ifc.weights_ready), 32'd0);
`else
        if (!good) x = 8'h00;
`endif
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        ifc.load_start  = 1'b0;
        ifc.in_valid    = 1'b0;
        ifc.in_byte     = 8'h00;
        ifc.weight_addr = 13'd0;
        ifc.bias_addr   = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wdata", 32'(ifc.weight_data), 32'd0);
        check("rst_bdata", ifc.bias_data, 32'd0);
        check("rst_ready", 32'(ifc.weights_ready), 32'd0);
        check("rst_loading", 32'(ifc.loading), 32'd0);
        check("rst_error", 32'(ifc.load_error), 32'd0);
        rst = 1'b0;

        // Idle ignores bytes; out-of-range reads return 0
        tick(1'b0, 1'b1, 8'h12, 7840, 10, 1'b1, "oor_idle", 0, 32'd0);
        tick(1'b0, 1'b1, 8'h34, 8191, 15, 1'b1, "oor_max", 0, 32'd0);
        idle();
        check("idle_loading", 32'(ifc.loading), 32'd0);
        check("idle_ready", 32'(ifc.weights_ready), 32'd0);

        // Load 1: weight k = k mod 256, bias N = N*10000
        tick(1'b1, 1'b0, 8'h00, 0, 0, 1'b0, "", 0, 32'd0);
        send_load(0, 1'b1);
        idle();
        check("l1_ready", 32'(ifc.weights_ready), 32'd1);
        check("l1_loading", 32'(ifc.loading), 32'd0);
        check("l1_error", 32'(ifc.load_error), 32'd0);
        // Byte in READY must be ignored (address 0 stays 0)
        tick(1'b0, 1'b1, 8'hEE, 2357, 9, 1'b1, "a2357", 8'h35, 32'd90000);
        rd("a7839", 7839, 3, 8'h9F, 32'd30000);
        rd("oor", 7840, 10, 0, 32'd0);
        rd("a0", 0, 0, 0, 32'd0);
        rd("a784", 784, 1, 8'h10, 32'd10000);
        rd("a2357b", 2357, 9, 8'h35, 32'd90000);
        idle();
        check("l1_ready_hold", 32'(ifc.weights_ready), 32'd1);

        // Load 2: abandoned after 1000 bytes, restart with a coincident byte, then 0x81 image
        tick(1'b1, 1'b0, 8'h00, 0, 0, 1'b0, "", 0, 32'd0);
        for (int k = 0; k < 1000; k++) tick(1'b0, 1'b1, 8'h55, 0, 0, 1'b0, "", 0, 32'd0);
        check("partial_ready", 32'(ifc.weights_ready), 32'd0);
        tick(1'b1, 1'b1, 8'hAA, 0, 0, 1'b0, "", 0, 32'd0);
        send_load(1, 1'b1);
        idle();
        check("l2_ready", 32'(ifc.weights_ready), 32'd1);
        check("l2_error", 32'(ifc.load_error), 32'd0);
        rd("a500", 500, 9, 8'h81, 32'hFFFF_FFF7);
        rd("a0_restart", 0, 0, 8'h01, 32'd0);
        rd("a7839_n", 7839, 1, 8'h81, 32'hFFFF_FFFF);
        rd("a1000_n", 1000, 5, 8'h81, 32'hFFFF_FFFB);
        idle();

        // Load 3: reset at byte 4000
        tick(1'b1, 1'b0, 8'h00, 0, 0, 1'b0, "", 0, 32'd0);
        check("ready_until_edge", 32'(ifc.weights_ready), 32'd1);
        for (int k = 0; k < 4000; k++) begin
            tick(1'b0, 1'b1, 8'h33, 0, 0, 1'b0, "", 0, 32'd0);
            if (k == 0) begin
                check("ready_drop", 32'(ifc.weights_ready), 32'd0);
                check("l3_loading", 32'(ifc.loading), 32'd1);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_loading", 32'(ifc.loading), 32'd0);
        check("mid_rst_ready", 32'(ifc.weights_ready), 32'd0);
        for (int k = 0; k < 50; k++) tick(1'b0, 1'b1, 8'h44, 0, 0, 1'b0, "", 0, 32'd0);
        check("post_rst_loading", 32'(ifc.loading), 32'd0);
        rd("a0_rst", 0, 0, 8'h33, 32'd0);
        rd("a3999_rst", 3999, 9, 8'h33, 32'hFFFF_FFF7);
        rd("a4001_rst", 4001, 2, 8'h81, 32'hFFFF_FFFE);
        idle();
        check("post_rst_ready", 32'(ifc.weights_ready), 32'd0);

`ifdef WBS_CHECKSUM_EN
        // Load 4: wrong checksum byte
        tick(1'b1, 1'b0, 8'h00, 0, 0, 1'b0, "", 0, 32'd0);
        send_load(0, 1'b0);
        idle();
        check("bad_ready", 32'(ifc.weights_ready), 32'd0);
        check("bad_error", 32'(ifc.load_error), 32'd1);
        check("bad_loading", 32'(ifc.loading), 32'd0);
        idle();
        check("bad_error_hold", 32'(ifc.load_error), 32'd1);
        tick(1'b1, 1'b0, 8'h00, 0, 0, 1'b0, "", 0, 32'd0);
        idle();
        check("error_cleared", 32'(ifc.load_error), 32'd0);
        check("reload_loading", 32'(ifc.loading), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
